// File: rtl/led_code_sequencer.sv
// rtl/led_code_sequencer.sv - code/enable source for the 4x16 LED decoder: synced switches, debounced
// buttons, OFF/MANUAL/SCAN mode FSM and a prescaled up/down code scanner.
module led_code_sequencer #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] SW_IN,
  input  logic       BTN_MODE,
  input  logic       BTN_DIR,
  output logic [3:0] code_out,
  output logic       dec_enable,
  output logic [1:0] mode_out,
  output logic       dir_out
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PSW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_MANUAL = 2'b01,
    ST_SCAN   = 2'b10
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [3:0]           sw_s1;
  logic [3:0]           sw_s2;
  logic [1:0]           btn_raw;
  logic [1:0]           btn_s1;
  logic [1:0]           btn_s2;
  logic [1:0][DBW-1:0]  db_cnt;
  logic [1:0]           db_state;
  logic [1:0]           press;
  logic [PSW-1:0]       presc;
  logic                 mode_press;
  logic                 dir_press;

  // Bit 0 is the mode button, bit 1 the direction button.
  assign btn_raw    = {BTN_DIR, BTN_MODE};
  assign mode_press = press[0];
  assign dir_press  = press[1];
  assign mode_out   = state;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= SW_IN;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // A level must differ from the accepted state for DB_CYCLES consecutive samples to flip it.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      db_cnt   <= '0;
      db_state <= '0;
      press    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (btn_s2[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_state[i] <= ~db_state[i];
          db_cnt[i]   <= '0;
          press[i]    <= ~db_state[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state <= ST_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:    if (mode_press) state_next = ST_MANUAL;
      ST_MANUAL: if (mode_press) state_next = ST_SCAN;
      ST_SCAN:   if (mode_press) state_next = ST_OFF;
      default:   state_next = ST_OFF;
    endcase
  end

  // A mode press in SCAN pre-empts the step; the prescaler idles at zero outside SCAN.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      code_out   <= '0;
      dec_enable <= 1'b0;
      dir_out    <= 1'b0;
      presc      <= '0;
    end else begin
      dir_out    <= dir_out ^ dir_press;
      dec_enable <= (state_next == ST_MANUAL) || (state_next == ST_SCAN);
      if (state == ST_MANUAL) begin
        code_out <= sw_s2;
      end
      if ((state == ST_SCAN) && !mode_press) begin
        if (presc == PS_LAST) begin
          presc    <= '0;
          code_out <= dir_out ? (code_out - 4'd1) : (code_out + 4'd1);
        end else begin
          presc <= presc + PSW'(1);
        end
      end else begin
        presc <= '0;
      end
    end
  end

endmodule
